// File: rtl/count_monitor_pkg.sv
// Shared types and default widths for count_monitor.
// FSM states: ACQ (no reference), LOCK, FAULT.
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int CW_DEF    = 3;
  localparam int WRAPW_DEF = 8;
  localparam int ERRW_DEF  = 4;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating tally with synchronous clear.
// An increment that coincides with a clear leaves the tally at 1.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Checks an up counter advances by +1 mod 2^CW; flags wraps and faults.
// Macro COUNT_MONITOR_WRAP_TALLY_EN enables the WRAPS tally register.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int WRAPW = WRAPW_DEF,
  parameter int ERRW  = ERRW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CW-1:0]    CNT,
  input  logic             CNT_VLD,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             WRAP,
  output logic [WRAPW-1:0] WRAPS,
  output logic             ERR,
  output logic [ERRW-1:0]  ERR_CNT
);

  state_t        state;
  logic [CW-1:0] prev;
  logic [CW-1:0] exp;
  logic          checking;
  logic          mismatch;
  logic          fault;
  logic          wrap_hit;

  assign exp      = prev + CW'(1);
  assign checking = CNT_VLD && (state != ACQ);
  assign mismatch = (CNT != exp);
  assign fault    = checking && mismatch;
  assign wrap_hit = checking && (&prev) && (CNT == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ACQ;
      prev   <= '0;
      LOCKED <= 1'b0;
      WRAP   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      WRAP <= wrap_hit;
      if (fault)
        ERR <= 1'b1;
      else if (CLR_ERR)
        ERR <= 1'b0;
      if (CNT_VLD) begin
        prev <= CNT;
        case (state)
          ACQ: begin
            state  <= LOCK;
            LOCKED <= 1'b1;
          end
          LOCK: begin
            if (mismatch) begin
              state  <= FAULT;
              LOCKED <= 1'b0;
            end
          end
          FAULT: begin
            if (!mismatch) begin
              state  <= LOCK;
              LOCKED <= 1'b1;
            end
          end
          default: begin
            state  <= ACQ;
            LOCKED <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERRW)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (fault),
    .clr (CLR_ERR),
    .q   (ERR_CNT)
  );

`ifdef COUNT_MONITOR_WRAP_TALLY_EN
  sat_counter #(.W(WRAPW)) u_wraps (
    .clk (CLK),
    .rst (RST),
    .inc (wrap_hit),
    .clr (1'b0),
    .q   (WRAPS)
  );
`else
  assign WRAPS = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Directed and randomized checks of count_monitor against a reference model.
module tb_count_monitor;

  localparam int CW    = 3;
  localparam int WRAPW = 8;
  localparam int ERRW  = 4;
  localparam int MOD   = 1 << CW;
  localparam int WMAX  = (1 << WRAPW) - 1;
  localparam int EMAX  = (1 << ERRW) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [CW-1:0]    CNT = '0;
  logic             CNT_VLD = 1'b0;
  logic             CLR_ERR = 1'b0;
  logic             LOCKED;
  logic             WRAP;
  logic [WRAPW-1:0] WRAPS;
  logic             ERR;
  logic [ERRW-1:0]  ERR_CNT;

  count_monitor #(.CW(CW), .WRAPW(WRAPW), .ERRW(ERRW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CNT     (CNT),
    .CNT_VLD (CNT_VLD),
    .CLR_ERR (CLR_ERR),
    .LOCKED  (LOCKED),
    .WRAP    (WRAP),
    .WRAPS   (WRAPS),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference state
  bit m_have;
  bit m_sync;
  int m_prev;
  bit m_wrap;
  bit m_err;
  int m_errs;
  int m_wraps;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input int c, input bit clr);
    bit f;
    bit w;
    f = 0;
    w = 0;
    if (r) begin
      m_have = 0; m_sync = 0; m_prev = 0;
      m_wrap = 0; m_err = 0; m_errs = 0; m_wraps = 0;
      return;
    end
    if (v) begin
      if (!m_have) begin
        m_have = 1;
        m_sync = 1;
      end else begin
        f = (c != (m_prev + 1) % MOD);
        w = (m_prev == MOD - 1) && (c == 0);
        m_sync = !f;
      end
      m_prev = c;
    end
    if (clr) begin
      m_err = 0;
      m_errs = 0;
    end
    if (f) begin
      m_err = 1;
      if (m_errs < EMAX) m_errs++;
    end
    if (w && m_wraps < WMAX) m_wraps++;
    m_wrap = w;
  endtask

  task automatic cyc(input bit r, input bit v, input int c, input bit clr);
    int want_wraps;
    RST = r;
    CNT_VLD = v;
    CNT = CW'(c);
    CLR_ERR = clr;
    @(posedge CLK);
    model(r, v, c, clr);
    #1;
`ifdef COUNT_MONITOR_WRAP_TALLY_EN
    want_wraps = m_wraps;
`else
    want_wraps = 0;
`endif
    chk("locked", int'(LOCKED), int'(m_have && m_sync));
    chk("wrap", int'(WRAP), int'(m_wrap));
    chk("wraps", int'(WRAPS), want_wraps);
    chk("err", int'(ERR), int'(m_err));
    chk("err_cnt", int'(ERR_CNT), m_errs);
  endtask

  task automatic smp(input int c);
    cyc(0, 1, c, 0);
  endtask

  initial begin
    int v;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 5, 1);
    chk("reset_locked", int'(LOCKED), 0);
    chk("reset_err_cnt", int'(ERR_CNT), 0);

    for (int i = 0; i < 10; i++) smp(i % MOD);
    chk("seq_wraps_dir", int'(WRAPS),
`ifdef COUNT_MONITOR_WRAP_TALLY_EN
      1
`else
      0
`endif
    );
    chk("seq_err_dir", int'(ERR), 0);

    smp(2); smp(3); smp(5);
    chk("skip_locked", int'(LOCKED), 0);
    chk("skip_err_cnt", int'(ERR_CNT), 1);
    smp(6);
    chk("resync_locked", int'(LOCKED), 1);
    chk("resync_err", int'(ERR), 1);

    for (int i = 7; i < 13; i++) smp(i % MOD);
    for (int i = 0; i < 3; i++) smp(4);
    chk("stuck_err_cnt", int'(ERR_CNT), 4);
    for (int i = 0; i < 20; i++) smp(4);
    chk("stuck_sat", int'(ERR_CNT), EMAX);

    cyc(0, 1, 4, 1);
    chk("clr_fault_cnt", int'(ERR_CNT), 1);
    cyc(0, 0, 0, 1);
    chk("clr_only_err", int'(ERR), 0);

    smp(5); smp(6); smp(7);
    for (int i = 0; i < 300 * MOD; i++) begin
      smp(i % MOD);
      if (i % 3 == 1) cyc(0, 0, $urandom_range(0, MOD - 1), 0);
    end

    for (int i = 0; i < 6; i++) smp(i);
    cyc(1, 1, 6, 0);
    smp(2); smp(3); smp(4);
    chk("post_rst_err", int'(ERR), 0);
    chk("post_rst_locked", int'(LOCKED), 1);

    v = $urandom_range(0, MOD - 1);
    for (int i = 0; i < 4000; i++) begin
      bit r, vl, cl;
      int pick;
      r  = ($urandom_range(0, 199) == 0);
      vl = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 29) == 0);
      pick = $urandom_range(0, 9);
      if (vl) begin
        if (pick < 7) v = (v + 1) % MOD;
        else if (pick < 9) v = $urandom_range(0, MOD - 1);
      end
      cyc(r, vl, v, cl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
